wave_gen_nco: RTL and testbench

- Parametrised waveform generator. A phase accumulator (NCO) drives a per-sample function generator with modes zero, sawtooth, triangle and square-with-duty.
- Sits between the frequency/mode control logic and the DAC/PWM output stage of the signal generator.
- Replaces externally indexed waveform lookup with an internal, frequency-programmable phase and glitch-free mode switching.

---
 rtl/wave_gen_pkg.sv | 17 +
 rtl/wave_gen_shape.sv | 38 +++
 rtl/wave_gen_nco.sv | 109 ++++++++++
 tb/tb_wave_gen_nco.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_gen_pkg.sv
// Shared mode encodings and index-slice helpers for the NCO waveform generator.
package wave_gen_pkg;

    localparam logic [1:0] MODE_ZERO = 2'b00;
    localparam logic [1:0] MODE_SAW  = 2'b01;
    localparam logic [1:0] MODE_TRI  = 2'b10;
    localparam logic [1:0] MODE_SQR  = 2'b11;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PHASE_W = 16;

    // Lowest accumulator bit that feeds the sample index (index = top WIDTH bits).
    function automatic int idx_lsb(input int phase_w, input int width);
        return phase_w - width;
    endfunction

endpackage

// File: rtl/wave_gen_shape.sv
// Combinational per-sample waveform function F(mode, idx, duty).
// Stateless, so table generators can reuse it directly.
module wave_gen_shape
    import wave_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] idx,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] shape
);

    logic [WIDTH-1:0] tri_fold;

    // Triangle = idx shifted left, inverted on the falling half (idx MSB set).
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fold
            if (gi == 0) begin : g_lsb
                assign tri_fold[gi] = idx[WIDTH-1];
            end else begin : g_upper
                assign tri_fold[gi] = idx[gi-1] ^ idx[WIDTH-1];
            end
        end
    endgenerate

    always_comb begin
        shape = '0;
        case (mode)
            MODE_SAW: shape = idx;
            MODE_TRI: shape = tri_fold;
            MODE_SQR: shape = (idx < duty) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            default:  shape = '0;
        endcase
    end

endmodule

// File: rtl/wave_gen_nco.sv
// Phase-accumulator waveform generator with mode switching at period boundaries.
// Optional amplitude scaling stage enabled by defining WAVE_GEN_AMP_EN.
module wave_gen_nco
    import wave_gen_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [1:0]         f,
    input  logic [PHASE_W-1:0] step,
    input  logic [WIDTH-1:0]   duty,
`ifdef WAVE_GEN_AMP_EN
    input  logic [WIDTH-1:0]   amp,
`endif
    output logic [WIDTH-1:0]   value,
    output logic               valid,
    output logic               wrap
);

    localparam int IDX_LSB = idx_lsb(PHASE_W, WIDTH);

    logic [PHASE_W-1:0] acc_reg;
    logic [1:0]         mode_reg;
    logic [WIDTH-1:0]   value_reg;
    logic               valid_reg;
    logic               wrap_reg;

    logic [PHASE_W:0]   sum;
    logic [WIDTH-1:0]   idx;
    logic [WIDTH-1:0]   shape;

    assign sum = {1'b0, acc_reg} + {1'b0, step};
    assign idx = acc_reg[PHASE_W-1:IDX_LSB];

    wave_gen_shape #(.WIDTH(WIDTH)) u_shape (
        .mode  (mode_reg),
        .idx   (idx),
        .duty  (duty),
        .shape (shape)
    );

    // While running, a new mode is only taken on the carry so the current
    // period always finishes in the old shape.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            mode_reg  <= MODE_ZERO;
            value_reg <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else if (sync_clr) begin
            acc_reg   <= '0;
            mode_reg  <= f;
            value_reg <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else if (en) begin
            acc_reg   <= sum[PHASE_W-1:0];
            wrap_reg  <= sum[PHASE_W];
            value_reg <= shape;
            valid_reg <= 1'b1;
            if (sum[PHASE_W]) begin
                mode_reg <= f;
            end
        end else begin
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            mode_reg  <= f;
        end
    end

`ifdef WAVE_GEN_AMP_EN
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   value_amp_reg;
    logic               valid_amp_reg;
    logic               wrap_amp_reg;

    assign product = {{WIDTH{1'b0}}, value_reg} * {{WIDTH{1'b0}}, amp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_amp_reg <= '0;
            valid_amp_reg <= 1'b0;
            wrap_amp_reg  <= 1'b0;
        end else if (sync_clr) begin
            value_amp_reg <= '0;
            valid_amp_reg <= 1'b0;
            wrap_amp_reg  <= 1'b0;
        end else begin
            value_amp_reg <= WIDTH'(product >> WIDTH);
            valid_amp_reg <= valid_reg;
            wrap_amp_reg  <= wrap_reg;
        end
    end

    assign value = value_amp_reg;
    assign valid = valid_amp_reg;
    assign wrap  = wrap_amp_reg;
`else
    assign value = value_reg;
    assign valid = valid_reg;
    assign wrap  = wrap_reg;
`endif

endmodule

// File: tb/tb_wave_gen_nco.sv
// Directed self-checking bench for wave_gen_nco (WIDTH=8, PHASE_W=16).
// With WAVE_GEN_AMP_EN defined only the amplitude scenarios run.
module tb_wave_gen_nco;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sync_clr;
    logic [1:0]  f;
    logic [15:0] step;
    logic [7:0]  duty;
`ifdef WAVE_GEN_AMP_EN
    logic [7:0]  amp;
`endif
    logic [7:0]  value;
    logic        valid;
    logic        wrap;

    int errors = 0;
    int checks = 0;

    wave_gen_nco #(.WIDTH(8), .PHASE_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync_clr (sync_clr),
        .f        (f),
        .step     (step),
        .duty     (duty),
`ifdef WAVE_GEN_AMP_EN
        .amp      (amp),
`endif
        .value    (value),
        .valid    (valid),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_to(input logic [1:0] mode);
        sync_clr = 1'b1;
        f        = mode;
        tick();
        sync_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0;
        f = 2'b01; step = 16'h0100; duty = 8'h00;
`ifdef WAVE_GEN_AMP_EN
        amp = 8'h80;
`endif
        #12;
        checks++; if (value !== 8'h00) begin errors++; $display("FAIL reset_value got=%h exp=00", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        tick();
        rst_n = 1'b1;
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_sawtooth();
        tick();  // idle edge loads f=sawtooth into the mode register
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL saw_idle_valid got=%b exp=0", valid); end
        en = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            tick();
            checks++; if (value !== 8'(i)) begin errors++; $display("FAIL saw_value i=%0d got=%h exp=%h", i, value, 8'(i)); end
            checks++; if (wrap !== (i == 255)) begin errors++; $display("FAIL saw_wrap i=%0d got=%b exp=%b", i, wrap, (i == 255)); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL saw_valid i=%0d got=%b exp=1", i, valid); end
        end
        $display("test_sawtooth done: errors=%0d", errors);
    endtask

    task automatic test_triangle();
        logic [7:0] exp_v;
        step = 16'h0100;
        clear_to(2'b10);
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            case (i)
                8'h00:   exp_v = 8'h00;
                8'h40:   exp_v = 8'h80;
                8'h80:   exp_v = 8'hFF;
                8'hC0:   exp_v = 8'h7F;
                8'hFF:   exp_v = 8'h01;
                default: exp_v = 8'hxx;
            endcase
            if (i == 0 || i == 'h40 || i == 'h80 || i == 'hC0 || i == 'hFF) begin
                checks++; if (value !== exp_v) begin errors++; $display("FAIL tri_value idx=%h got=%h exp=%h", i[7:0], value, exp_v); end
            end
        end
        $display("test_triangle done: errors=%0d", errors);
    endtask

    task automatic test_square();
        step = 16'h0100;
        duty = 8'h40;
        en   = 1'b0;
        clear_to(2'b11);
        checks++; if (value !== 8'h00) begin errors++; $display("FAIL sqr_clr_value got=%h exp=00", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sqr_clr_valid got=%b exp=0", valid); end
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            checks++;
            if (value !== ((i < 'h40) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL sqr_value idx=%h got=%h exp=%h", i[7:0], value, (i < 'h40) ? 8'hFF : 8'h00);
            end
        end
        duty = 8'h00;
        clear_to(2'b11);
        for (int i = 0; i < 256; i++) begin
            tick();
            checks++; if (value !== 8'h00) begin errors++; $display("FAIL sqr_duty0 idx=%h got=%h exp=00", i[7:0], value); end
        end
        $display("test_square done: errors=%0d", errors);
    endtask

    task automatic test_glitch_switch();
        step = 16'h0100;
        clear_to(2'b01);
        en = 1'b1;
        for (int i = 0; i <= 'h30; i++) tick();
        checks++; if (value !== 8'h30) begin errors++; $display("FAIL sw_pre got=%h exp=30", value); end
        f = 2'b10;
        for (int i = 'h31; i <= 'hFF; i++) begin
            tick();
            checks++; if (value !== 8'(i)) begin errors++; $display("FAIL sw_saw_tail i=%h got=%h exp=%h", i[7:0], value, 8'(i)); end
        end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL sw_wrap got=%b exp=1", wrap); end
        tick();
        checks++; if (value !== 8'h00) begin errors++; $display("FAIL sw_tri0 got=%h exp=00", value); end
        tick();
        checks++; if (value !== 8'h02) begin errors++; $display("FAIL sw_tri1 got=%h exp=02", value); end
        $display("test_glitch_switch done: errors=%0d", errors);
    endtask

    task automatic test_step_max();
        step = 16'hFFFF;
        clear_to(2'b01);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (wrap !== (i > 0)) begin errors++; $display("FAIL stepmax_wrap i=%0d got=%b exp=%b", i, wrap, (i > 0)); end
        end
        $display("test_step_max done: errors=%0d", errors);
    endtask

    task automatic test_en_hold();
        step = 16'h0100;
        clear_to(2'b01);
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (value !== 8'h09) begin errors++; $display("FAIL hold_pre got=%h exp=09", value); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (value !== 8'h09) begin errors++; $display("FAIL hold_value c=%0d got=%h exp=09", i, value); end
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_valid c=%0d got=%b exp=0", i, valid); end
            checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap c=%0d got=%b exp=0", i, wrap); end
        end
        en = 1'b1;
        tick();
        checks++; if (value !== 8'h0A) begin errors++; $display("FAIL hold_resume got=%h exp=0a", value); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hold_resume_valid got=%b exp=1", valid); end
        $display("test_en_hold done: errors=%0d", errors);
    endtask

    task automatic test_step_zero();
        step = 16'h0300;
        clear_to(2'b01);
        en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (value !== 8'h06) begin errors++; $display("FAIL step3_value got=%h exp=06", value); end
        step = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (value !== 8'h09) begin errors++; $display("FAIL step0_value c=%0d got=%h exp=09", i, value); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL step0_valid c=%0d got=%b exp=1", i, valid); end
            checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL step0_wrap c=%0d got=%b exp=0", i, wrap); end
        end
        $display("test_step_zero done: errors=%0d", errors);
    endtask

    task automatic test_async_reset();
        step = 16'h0100;
        clear_to(2'b01);
        en = 1'b1;
        for (int i = 0; i < 'h20; i++) tick();
        checks++; if (value !== 8'h1F) begin errors++; $display("FAIL areset_pre got=%h exp=1f", value); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (value !== 8'h00) begin errors++; $display("FAIL areset_value got=%h exp=00", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap got=%b exp=0", wrap); end
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();
        checks++; if (value !== 8'h00) begin errors++; $display("FAIL areset_acc0 got=%h exp=00", value); end
        tick();
        checks++; if (value !== 8'h01) begin errors++; $display("FAIL areset_acc1 got=%h exp=01", value); end
        $display("test_async_reset done: errors=%0d", errors);
    endtask

`ifdef WAVE_GEN_AMP_EN
    task automatic test_amp();
        step = 16'h0100;
        amp  = 8'h80;
        en   = 1'b0;
        clear_to(2'b01);
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL amp_first_valid got=%b exp=0", valid); end
            end else begin
                checks++; if (value !== 8'((k - 2) >> 1)) begin errors++; $display("FAIL amp_half k=%0d got=%h exp=%h", k, value, 8'((k - 2) >> 1)); end
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL amp_valid k=%0d got=%b exp=1", k, valid); end
            end
        end
        amp = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (value !== 8'h00) begin errors++; $display("FAIL amp_zero k=%0d got=%h exp=00", k, value); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL amp_zero_valid k=%0d got=%b exp=1", k, valid); end
        end
        $display("test_amp done: errors=%0d", errors);
    endtask
`endif

    initial begin
        test_reset();
`ifdef WAVE_GEN_AMP_EN
        test_amp();
`else
        test_sawtooth();
        test_triangle();
        test_square();
        test_glitch_switch();
        test_step_max();
        test_en_hold();
        test_step_zero();
        test_async_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
